hough_accum_ctrl: RTL and testbench

//  Sequences the Hough accumulator RAM for one frame: clear -> vote -> drain.
//  - Clear: zeroes the RAM.
//  - Vote: turns (rho,theta) address votes from the transform into saturating

---
 rtl/hough_accum_ctrl_if.sv | 24 ++
 rtl/hough_accum_ctrl.sv | 155 +++++++++++++++
 tb/tb_hough_accum_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hough_accum_ctrl_if.sv
// Vote and drain streams of the Hough accumulator controller.
interface hough_accum_ctrl_if #(
  parameter int ADDR_BITS  = 16,
  parameter int COUNT_BITS = 8
);
  logic                  vote_valid;
  logic                  vote_ready;
  logic [ADDR_BITS-1:0]  vote_addr;
  logic                  vote_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_BITS-1:0]  out_addr;
  logic [COUNT_BITS-1:0] out_data;

  modport master (
    output vote_valid, vote_addr, vote_last, out_ready,
    input  vote_ready, out_valid, out_addr, out_data
  );

  modport slave (
    input  vote_valid, vote_addr, vote_last, out_ready,
    output vote_ready, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/hough_accum_ctrl.sv
// Hough accumulator RAM sequencer: clear, saturating vote read-modify-write
// with same-address forwarding, then in-order drain through a 2-entry skid buffer.
module hough_accum_ctrl #(
  parameter int THETAS     = 180,
  parameter int RHOS       = 256,
  parameter int DEPTH      = 46080,
  parameter int ADDR_BITS  = 16,
  parameter int COUNT_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  hough_accum_ctrl_if.slave     bus,
  output logic [ADDR_BITS-1:0]  mem_rd_addr,
  input  logic [COUNT_BITS-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_BITS-1:0]  mem_wr_addr,
  output logic [COUNT_BITS-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  frame_done
);

  if (THETAS * RHOS != DEPTH || (2 ** ADDR_BITS) < DEPTH) begin : g_bad_params
    $error("hough_accum_ctrl: DEPTH must equal THETAS*RHOS and fit in ADDR_BITS");
  end

  typedef enum logic [2:0] {IDLE, CLEAR, VOTE, FLUSH, DRAIN} state_t;

  localparam logic [ADDR_BITS-1:0]  LAST = ADDR_BITS'(DEPTH - 1);
  localparam logic [COUNT_BITS-1:0] CMAX = '1;

  state_t                state;
  logic [ADDR_BITS-1:0]  cnt;
  logic                  s1_valid;
  logic [ADDR_BITS-1:0]  s1_addr;
  logic [COUNT_BITS-1:0] s1_old;
  logic [COUNT_BITS-1:0] s1_new;
  logic                  fwd_valid;
  logic [ADDR_BITS-1:0]  fwd_addr;
  logic [COUNT_BITS-1:0] fwd_data;
  logic                  rd_done;
  logic                  rd_pend;
  logic [ADDR_BITS-1:0]  rd_pend_addr;
  logic                  spare_valid;
  logic [ADDR_BITS-1:0]  spare_addr;
  logic [COUNT_BITS-1:0] spare_data;
  logic                  vote_fire;
  logic                  pop;
  logic                  rd_en;
  logic [1:0]            committed;

  always_comb begin
    vote_fire  = (state == VOTE) && bus.vote_valid;
    pop        = bus.out_valid && bus.out_ready;
    // Words held or in flight after this cycle's pop; a new read needs a free slot.
    committed  = 2'(bus.out_valid) + 2'(spare_valid) + 2'(rd_pend) - 2'(pop);
    rd_en      = (state == DRAIN) && !rd_done && (committed < 2'd2);
    // RAM returns the pre-write value on a collision, so the previous write is forwarded.
    s1_old     = (fwd_valid && fwd_addr == s1_addr) ? fwd_data : mem_rd_data;
    s1_new     = (s1_old == CMAX) ? s1_old : s1_old + COUNT_BITS'(1);

    mem_rd_addr = '0;
    if (state == VOTE)       mem_rd_addr = bus.vote_addr;
    else if (state == DRAIN) mem_rd_addr = cnt;

    mem_wr_en   = s1_valid || (state == CLEAR);
    mem_wr_addr = s1_valid ? s1_addr : ((state == CLEAR) ? cnt : '0);
    mem_wr_data = s1_valid ? s1_new : '0;

    bus.vote_ready = (state == VOTE);
    busy           = (state != IDLE);
    frame_done     = (state == DRAIN) && pop && (bus.out_addr == LAST);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      s1_valid     <= 1'b0;
      s1_addr      <= '0;
      fwd_valid    <= 1'b0;
      fwd_addr     <= '0;
      fwd_data     <= '0;
      rd_done      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_addr <= '0;
      spare_valid  <= 1'b0;
      spare_addr   <= '0;
      spare_data   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_data  <= '0;
    end else begin
      s1_valid <= vote_fire;
      if (vote_fire) s1_addr <= bus.vote_addr;
      fwd_valid <= s1_valid;
      fwd_addr  <= s1_addr;
      fwd_data  <= s1_new;

      rd_pend <= rd_en;
      if (rd_en) rd_pend_addr <= cnt;

      if (pop || !bus.out_valid) begin
        if (spare_valid) begin
          bus.out_addr <= spare_addr;
          bus.out_data <= spare_data;
          if (rd_pend) begin
            spare_addr <= rd_pend_addr;
            spare_data <= mem_rd_data;
          end else begin
            spare_valid <= 1'b0;
          end
        end else if (rd_pend) begin
          bus.out_valid <= 1'b1;
          bus.out_addr  <= rd_pend_addr;
          bus.out_data  <= mem_rd_data;
        end else begin
          bus.out_valid <= 1'b0;
        end
      end else if (rd_pend) begin
        spare_valid <= 1'b1;
        spare_addr  <= rd_pend_addr;
        spare_data  <= mem_rd_data;
      end

      case (state)
        IDLE: if (start) begin
          state <= CLEAR;
          cnt   <= '0;
        end
        CLEAR: if (cnt == LAST) begin
          state <= VOTE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + ADDR_BITS'(1);
        end
        VOTE: if (bus.vote_last) state <= FLUSH;
        FLUSH: begin
          state   <= DRAIN;
          cnt     <= '0;
          rd_done <= 1'b0;
        end
        DRAIN: begin
          if (rd_en) begin
            if (cnt == LAST) rd_done <= 1'b1;
            else             cnt     <= cnt + ADDR_BITS'(1);
          end
          if (frame_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hough_accum_ctrl.sv
// Randomized bench for hough_accum_ctrl on a 4x4 accumulator with 2-bit bins,
// checked against a per-bin saturating count model and a behavioural RAM.
module tb_hough_accum_ctrl;
  localparam int THETAS = 4;
  localparam int RHOS   = 4;
  localparam int DEPTH  = 16;
  localparam int AB     = 4;
  localparam int CB     = 2;
  localparam int CMAX   = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AB-1:0] mem_rd_addr;
  logic [CB-1:0] mem_rd_data;
  logic          mem_wr_en;
  logic [AB-1:0] mem_wr_addr;
  logic [CB-1:0] mem_wr_data;
  logic          busy;
  logic          frame_done;

  hough_accum_ctrl_if #(.ADDR_BITS(AB), .COUNT_BITS(CB)) bus ();

  hough_accum_ctrl #(
    .THETAS(THETAS), .RHOS(RHOS), .DEPTH(DEPTH), .ADDR_BITS(AB), .COUNT_BITS(CB)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .bus(bus.slave),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Simple dual-port RAM: registered read, old data on read/write collision.
  logic [CB-1:0] ram [DEPTH];
  logic          scramble = 1'b0;
  always @(posedge clock) begin
    if (scramble) for (int i = 0; i < DEPTH; i++) ram[i] <= CB'($urandom);
    else if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_rd_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int model [DEPTH];
  bit wr_due = 1'b0;
  int wr_due_addr;
  int wr_due_data;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic accept(input int a);
    model[a]    = (model[a] >= CMAX) ? CMAX : model[a] + 1;
    wr_due      = 1'b1;
    wr_due_addr = a;
    wr_due_data = model[a];
  endtask

  task automatic check_write(input string tag);
    if (wr_due) begin
      check({tag, "_wr_en"},   int'(mem_wr_en),   1);
      check({tag, "_wr_addr"}, int'(mem_wr_addr), wr_due_addr);
      check({tag, "_wr_data"}, int'(mem_wr_data), wr_due_data);
      wr_due = 1'b0;
    end else begin
      check({tag, "_wr_idle"}, int'(mem_wr_en), 0);
    end
  endtask

  task automatic clear_phase();
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    wr_due = 1'b0;
    @(posedge clock); #1;
    start = 1'b1;
    @(negedge clock);
    check("start_cycle_wr", int'(mem_wr_en), 0);
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      @(negedge clock);
      check("clear_word", int'({mem_wr_en, mem_wr_addr, mem_wr_data, bus.vote_ready}),
            int'({1'b1, AB'(i), CB'(0), 1'b0}));
      check("clear_busy", int'(busy), 1);
    end
  endtask

  // Entries >= 0 are votes, -1 is an idle cycle; the final entry carries vote_last.
  task automatic run_votes(input int q[$], input int stray_at);
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clock); #1;
      bus.vote_valid = (q[i] >= 0);
      bus.vote_addr  = (q[i] >= 0) ? AB'(q[i]) : AB'($urandom);
      bus.vote_last  = (i == q.size() - 1);
      start          = (i == stray_at);
      @(negedge clock);
      check("vote_ready", int'(bus.vote_ready), 1);
      check_write("vote");
      if (q[i] >= 0) accept(q[i]);
    end
    @(posedge clock); #1;
    bus.vote_valid = 1'b0;
    bus.vote_last  = 1'b0;
    start          = 1'b0;
    @(negedge clock);
    check("flush_ready", int'(bus.vote_ready), 0);
    check_write("flush");
  endtask

  // mode 0: out_ready 1,0,0,1 repeating; mode 1: random; mode 2: always ready.
  task automatic drain(input int mode, input int stray_at);
    int exp_addr = 0;
    int idx = 0;
    int first_valid = -1;
    int last_idx = -1;
    bit held = 1'b0;
    int held_addr = 0;
    int held_data = 0;
    while (exp_addr < DEPTH && idx < 300) begin
      @(posedge clock); #1;
      case (mode)
        0:       bus.out_ready = (idx % 4 == 0) || (idx % 4 == 3);
        1:       bus.out_ready = ($urandom_range(0, 1) == 1);
        default: bus.out_ready = 1'b1;
      endcase
      start = (idx == stray_at);
      @(negedge clock);
      check("drain_wr_idle", int'(mem_wr_en), 0);
      if (bus.out_valid && first_valid < 0) first_valid = idx;
      if (held) begin
        check("hold_valid", int'(bus.out_valid), 1);
        check("hold_addr", int'(bus.out_addr), held_addr);
        check("hold_data", int'(bus.out_data), held_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("out_addr", int'(bus.out_addr), exp_addr);
        check("out_data", int'(bus.out_data), model[exp_addr]);
        check("frame_done", int'(frame_done), int'(exp_addr == DEPTH - 1));
        exp_addr++;
        last_idx = idx;
      end else begin
        check("frame_done_quiet", int'(frame_done), 0);
      end
      held      = bus.out_valid && !bus.out_ready;
      held_addr = int'(bus.out_addr);
      held_data = int'(bus.out_data);
      idx++;
    end
    check("drain_words", exp_addr, DEPTH);
    check("first_valid_latency", first_valid, 2);
    if (mode == 2) check("drain_no_bubbles", last_idx - first_valid + 1, DEPTH);
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("post_frame_busy", int'(busy), 0);
    check("post_frame_valid", int'(bus.out_valid), 0);
    check("post_frame_done", int'(frame_done), 0);
  endtask

  task automatic random_votes(input int n, output int q[$]);
    q = {};
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 7) q.push_back(int'($urandom_range(0, DEPTH - 1)));
      else q.push_back(-1);
    end
    q.push_back(int'($urandom_range(0, DEPTH - 1)));
  endtask

  initial begin
    int q[$];
    bus.vote_valid = 1'b0;
    bus.vote_addr  = '0;
    bus.vote_last  = 1'b0;
    bus.out_ready  = 1'b0;
    scramble = 1'b1;
    repeat (3) @(posedge clock);
    #1 scramble = 1'b0;
    @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_vote_ready", int'(bus.vote_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_wr_en", int'(mem_wr_en), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_addrs", int'({mem_rd_addr, mem_wr_addr, bus.out_addr}), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("idle_busy", int'(busy), 0);

    // Frame 1: same-address hazard, saturation, backpressure pattern.
    clear_phase();
    q = '{5, 5, 5, 7, -1, 3, 3, 3, 3, 3, -1, -1, 9, 0, 15, 15};
    run_votes(q, -1);
    drain(0, -1);

    // Frame 2: random votes, stray starts in VOTE and DRAIN, random backpressure.
    clear_phase();
    random_votes(30, q);
    run_votes(q, 4);
    drain(1, 5);

    // Frame 3: reset after three votes abandons the frame.
    clear_phase();
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      bus.vote_valid = 1'b1;
      bus.vote_addr  = AB'(k + 1);
      @(negedge clock);
      check_write("abort_vote");
      accept(k + 1);
    end
    @(posedge clock); #1;
    bus.vote_valid = 1'b0;
    reset = 1'b0;
    start = 1'b1;
    @(negedge clock);
    check_write("abort_last");
    @(posedge clock); #1;
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    check("abort_busy", int'(busy), 0);
    check("abort_vote_ready", int'(bus.vote_ready), 0);
    check("abort_wr_en", int'(mem_wr_en), 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("abort_start_ignored", int'(busy), 0);

    // Frame 4: fresh frame after the abort, full-rate drain.
    clear_phase();
    random_votes(40, q);
    run_votes(q, -1);
    drain(2, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
